// File: rtl/clint_multi_hart_if.sv
// Register-port bundle between the LSU/AXI bridge (master) and the CLINT (slave).
// One access per cycle; read data and ack come back one cycle after sel.
interface clint_multi_hart_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   clint_addr;
  logic [DATA_WIDTH-1:0]   clint_wdata;
  logic [DATA_WIDTH/8-1:0] clint_wstrb;
  logic                    clint_wen;
  logic                    clint_sel;
  logic [DATA_WIDTH-1:0]   clint_rdata;
  logic                    clint_ack;

  modport master (
    output clint_addr, clint_wdata, clint_wstrb, clint_wen, clint_sel,
    input  clint_rdata, clint_ack
  );

  modport slave (
    input  clint_addr, clint_wdata, clint_wstrb, clint_wen, clint_sel,
    output clint_rdata, clint_ack
  );
endinterface

// File: rtl/clint_multi_hart.sv
// Multi-hart core-local interruptor: shared prescaled mtime, per-hart mtimecmp
// and msip, registered timer/software IRQ lines and a 1-cycle register port.
module clint_multi_hart #(
  parameter int          NUM_HARTS      = 2,
  parameter int          DATA_WIDTH     = 64,
  parameter int unsigned TICK_COUNT     = 32'h0000_0100,
  parameter int          PRESCALE_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  clint_multi_hart_if.slave    bus,
  output logic [NUM_HARTS-1:0] clint_tirq,
  output logic [NUM_HARTS-1:0] clint_sirq
);

  localparam int NB = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0]     mtime_q, mtime_d;
  logic [DATA_WIDTH-1:0]     mtimecmp_q [NUM_HARTS];
  logic [DATA_WIDTH-1:0]     mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0]      msip_q, msip_d;
  logic [NUM_HARTS-1:0]      tirq_q, tirq_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      ack_q, ack_d;

  logic [15:0]               off_s;
  logic                      wr_s, msip_hit_s, cmp_hit_s, presc_hit_s, mtime_hit_s;
  logic                      presc_wr_s, tick_s;
  logic [NUM_HARTS-1:0]      msip_sel_s, cmp_sel_s;
  logic [DATA_WIDTH-1:0]     rdval_s;
  logic                      unused_addr_s;

  assign unused_addr_s = ^bus.clint_addr[DATA_WIDTH-1:16];

  // Address decode and read-data mux; only the low 16 address bits select a register.
  always_comb begin
    off_s       = bus.clint_addr[15:0];
    wr_s        = bus.clint_sel & bus.clint_wen;
    msip_hit_s  = (off_s[15:6] == 10'd0) && (off_s[1:0] == 2'd0) &&
                  ({1'b0, off_s[5:2]} < 5'(NUM_HARTS));
    cmp_hit_s   = (off_s[15:7] == 9'h080) && (off_s[2:0] == 3'd0) &&
                  ({1'b0, off_s[6:3]} < 5'(NUM_HARTS));
    presc_hit_s = (off_s == 16'hbff0);
    mtime_hit_s = (off_s == 16'hbff8);
    rdval_s     = ({DATA_WIDTH{mtime_hit_s}} & mtime_q) |
                  ({DATA_WIDTH{presc_hit_s}} & DATA_WIDTH'(prescale_q));
    for (int h = 0; h < NUM_HARTS; h++) begin
      msip_sel_s[h] = msip_hit_s && (off_s[5:2] == 4'(h));
      cmp_sel_s[h]  = cmp_hit_s && (off_s[6:3] == 4'(h));
      rdval_s       = rdval_s | ({DATA_WIDTH{cmp_sel_s[h]}} & mtimecmp_q[h]) |
                      DATA_WIDTH'(msip_sel_s[h] & msip_q[h]);
    end
  end

  // Next-state: prescaler, mtime (a write beats a tick), per-hart registers and port outputs.
  always_comb begin
    presc_wr_s = wr_s & presc_hit_s;
    tick_s     = (cnt_q == prescale_q) && !presc_wr_s;
    cnt_d      = (presc_wr_s || (cnt_q == prescale_q)) ? '0 : cnt_q + PRESCALE_WIDTH'(1);
    for (int i = 0; i < PRESCALE_WIDTH / 8; i++) begin
      prescale_d[8*i +: 8] = (presc_wr_s && bus.clint_wstrb[i]) ?
                             bus.clint_wdata[8*i +: 8] : prescale_q[8*i +: 8];
    end
    if (wr_s && mtime_hit_s) begin
      mtime_d = byte_merge(mtime_q, bus.clint_wdata, bus.clint_wstrb);
    end else if (tick_s) begin
      mtime_d = mtime_q + DATA_WIDTH'(1);
    end else begin
      mtime_d = mtime_q;
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtimecmp_d[h] = (wr_s && cmp_sel_s[h]) ?
                      byte_merge(mtimecmp_q[h], bus.clint_wdata, bus.clint_wstrb) : mtimecmp_q[h];
      msip_d[h]     = (wr_s && msip_sel_s[h] && bus.clint_wstrb[0]) ? bus.clint_wdata[0] : msip_q[h];
      tirq_d[h]     = (mtime_q >= mtimecmp_q[h]);
    end
    rdata_d = bus.clint_sel ? rdval_s : rdata_q;
    ack_d   = bus.clint_sel;
  end

  // State registers, all cleared asynchronously; mtimecmp resets to all-ones to keep IRQs quiet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime_q    <= '0;
      msip_q     <= '0;
      tirq_q     <= '0;
      prescale_q <= PRESCALE_WIDTH'(TICK_COUNT);
      cnt_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= '1;
      end
    end else begin
      mtime_q    <= mtime_d;
      msip_q     <= msip_d;
      tirq_q     <= tirq_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
    end
  end

  assign bus.clint_rdata = rdata_q;
  assign bus.clint_ack   = ack_q;
  assign clint_tirq      = tirq_q;
  assign clint_sirq      = msip_q;

endmodule

// File: tb/tb_clint_multi_hart.sv
// Self-checking bench for clint_multi_hart: directed scenarios from the test plan
// plus randomized traffic checked against a cycle-level behavioural model.
module tb_clint_multi_hart;
  localparam int NH = 2;
  localparam int DW = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NH-1:0] clint_tirq, clint_sirq;
  int n_chk = 0;
  int n_fail = 0;

  clint_multi_hart_if #(.DATA_WIDTH(DW)) bus ();

  clint_multi_hart #(
    .NUM_HARTS(NH), .DATA_WIDTH(DW), .TICK_COUNT(32'h0000_0100), .PRESCALE_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .clint_tirq(clint_tirq), .clint_sirq(clint_sirq)
  );

  always #5 clock = ~clock;

  // Behavioural reference model state
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip, m_tirq;
  int unsigned   m_presc, m_cnt;
  logic [63:0]   m_rdata;
  logic          m_ack;
  int            m_o;
  bit            m_wr, m_pw, m_tick;

  function automatic logic [63:0] m_merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_read(input int o);
    if (o < 4*NH && o % 4 == 0) return 64'(m_msip[o/4]);
    if (o >= 'h4000 && o < 'h4000 + 8*NH && o % 8 == 0) return m_cmp[(o - 'h4000) / 8];
    if (o == 'hbff0) return 64'(m_presc);
    if (o == 'hbff8) return m_mtime;
    return 64'd0;
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_mtime = 64'd0; m_msip = '0; m_tirq = '0; m_presc = 32'h100; m_cnt = 0;
      m_rdata = 64'd0; m_ack = 1'b0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
    end else begin
      m_o  = int'(bus.clint_addr[15:0]);
      m_wr = bus.clint_sel && bus.clint_wen;
      if (bus.clint_sel) m_rdata = m_read(m_o);
      m_ack = bus.clint_sel;
      for (int h = 0; h < NH; h++) m_tirq[h] = (m_mtime >= m_cmp[h]);
      m_pw   = m_wr && (m_o == 'hbff0);
      m_tick = !m_pw && (m_cnt == m_presc);
      if (m_pw || m_cnt == m_presc) m_cnt = 0; else m_cnt = m_cnt + 1;
      if (m_wr && m_o == 'hbff8) m_mtime = m_merge(m_mtime, bus.clint_wdata, bus.clint_wstrb);
      else if (m_tick) m_mtime = m_mtime + 64'd1;
      if (m_pw) m_presc = 32'(m_merge(64'(m_presc), bus.clint_wdata, bus.clint_wstrb));
      for (int h = 0; h < NH; h++) begin
        if (m_wr && m_o == 'h4000 + 8*h) m_cmp[h] = m_merge(m_cmp[h], bus.clint_wdata, bus.clint_wstrb);
        if (m_wr && m_o == 4*h && bus.clint_wstrb[0]) m_msip[h] = bus.clint_wdata[0];
      end
    end
  end

  // One access: drive at a falling edge, return at the next one with outputs valid.
  task automatic bus_go(input logic [15:0] off, input logic [63:0] d, input logic [7:0] s, input logic w);
    bus.clint_addr = {48'h0, off}; bus.clint_wdata = d; bus.clint_wstrb = s;
    bus.clint_wen = w; bus.clint_sel = 1'b1;
    @(negedge clock);
    bus.clint_sel = 1'b0; bus.clint_wen = 1'b0;
  endtask

  task automatic test_reset();
    bus.clint_addr = '0; bus.clint_wdata = '0; bus.clint_wstrb = '0;
    bus.clint_wen = 1'b0; bus.clint_sel = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_chk++; if (bus.clint_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.clint_rdata); end
    n_chk++; if (bus.clint_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.clint_ack); end
    n_chk++; if (clint_tirq !== 2'b00 || clint_sirq !== 2'b00) begin n_fail++;
      $display("FAIL reset_irq: got tirq=%b sirq=%b want 00/00", clint_tirq, clint_sirq); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_mtime_idle();
    repeat (3 * 257) @(negedge clock);
    bus_go(16'hbff8, 64'd0, 8'h00, 1'b0);
    n_chk++; if (bus.clint_rdata !== 64'd3) begin n_fail++; $display("FAIL mtime_idle: got %0d want 3", bus.clint_rdata); end
    n_chk++; if (bus.clint_ack !== 1'b1) begin n_fail++; $display("FAIL mtime_idle_ack: got %b want 1", bus.clint_ack); end
    n_chk++; if (clint_tirq !== 2'b00) begin n_fail++; $display("FAIL mtime_idle_tirq: got %b want 00", clint_tirq); end
  endtask

  task automatic test_timer_irq();
    bus_go(16'hbff0, 64'd0, 8'hFF, 1'b1);
    bus_go(16'h4008, 64'd10, 8'hFF, 1'b1);
    bus_go(16'hbff8, 64'd0, 8'hFF, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      n_chk++; if (clint_tirq[1] !== (k >= 11)) begin n_fail++;
        $display("FAIL timer_tirq1 cycle %0d: got %b want %b", k, clint_tirq[1], (k >= 11)); end
      n_chk++; if (clint_tirq[0] !== 1'b0) begin n_fail++; $display("FAIL timer_tirq0 cycle %0d: got %b want 0", k, clint_tirq[0]); end
    end
  endtask

  task automatic test_mtime_wrap();
    bus_go(16'hbff8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    @(negedge clock);
    bus_go(16'hbff8, 64'd0, 8'h00, 1'b0);
    n_chk++; if (bus.clint_rdata !== 64'd0) begin n_fail++; $display("FAIL mtime_wrap: got %h want 0", bus.clint_rdata); end
    bus_go(16'hbff8, 64'd5, 8'hFF, 1'b1);
    bus_go(16'hbff8, 64'd0, 8'h00, 1'b0);
    n_chk++; if (bus.clint_rdata !== 64'd5) begin n_fail++; $display("FAIL mtime_write_vs_tick: got %0d want 5", bus.clint_rdata); end
  endtask

  task automatic test_byte_strobe();
    bus_go(16'h4000, 64'h0000_0000_0000_00AA, 8'h01, 1'b1);
    bus_go(16'h4000, 64'd0, 8'h00, 1'b0);
    n_chk++; if (bus.clint_rdata !== 64'hFFFF_FFFF_FFFF_FFAA) begin n_fail++;
      $display("FAIL strobe_cmp0: got %h want ffffffffffffffaa", bus.clint_rdata); end
    bus_go(16'h4000 + 16'(8*NH), 64'h1234_5678, 8'hFF, 1'b1);
    n_chk++; if (bus.clint_ack !== 1'b1) begin n_fail++; $display("FAIL oob_write_ack: got %b want 1", bus.clint_ack); end
    bus_go(16'h4000 + 16'(8*NH), 64'd0, 8'h00, 1'b0);
    n_chk++; if (bus.clint_rdata !== 64'd0 || bus.clint_ack !== 1'b1) begin n_fail++;
      $display("FAIL oob_read: got rdata=%h ack=%b want 0/1", bus.clint_rdata, bus.clint_ack); end
    bus_go(16'hbff0, 64'd0, 8'h00, 1'b0);
    n_chk++; if (bus.clint_rdata !== 64'd0) begin n_fail++; $display("FAIL prescale_read: got %h want 0", bus.clint_rdata); end
  endtask

  task automatic test_back_to_back();
    bus_go(16'h4008, 64'h55, 8'hFF, 1'b1);
    n_chk++; if (bus.clint_rdata !== 64'd10) begin n_fail++; $display("FAIL read_during_write: got %h want a", bus.clint_rdata); end
    bus_go(16'h4008, 64'd0, 8'h00, 1'b0);
    n_chk++; if (bus.clint_rdata !== 64'h55 || bus.clint_ack !== 1'b1) begin n_fail++;
      $display("FAIL b2b_read: got rdata=%h ack=%b want 55/1", bus.clint_rdata, bus.clint_ack); end
    repeat (2) @(negedge clock);
    n_chk++; if (bus.clint_rdata !== 64'h55 || bus.clint_ack !== 1'b0) begin n_fail++;
      $display("FAIL rdata_hold: got rdata=%h ack=%b want 55/0", bus.clint_rdata, bus.clint_ack); end
  endtask

  task automatic test_msip();
    bus_go(16'h0004, 64'd1, 8'h01, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (clint_sirq !== 2'b10) begin n_fail++; $display("FAIL msip_set cycle %0d: got %b want 10", k, clint_sirq); end
      @(negedge clock);
    end
    bus_go(16'h0004, 64'd0, 8'h00, 1'b0);
    n_chk++; if (bus.clint_rdata !== 64'd1) begin n_fail++; $display("FAIL msip_read: got %h want 1", bus.clint_rdata); end
    bus_go(16'h0004, 64'd0, 8'h01, 1'b1);
    n_chk++; if (clint_sirq !== 2'b00) begin n_fail++; $display("FAIL msip_clear: got %b want 00", clint_sirq); end
  endtask

  task automatic test_random();
    logic [63:0] a;
    bus_go(16'hbff0, 64'd2, 8'h01, 1'b1);
    for (int i = 0; i < 400; i++) begin
      n_chk++; if (bus.clint_rdata !== m_rdata || bus.clint_ack !== m_ack) begin n_fail++;
        $display("FAIL rand_port %0d: got rdata=%h ack=%b want %h/%b", i, bus.clint_rdata, bus.clint_ack, m_rdata, m_ack); end
      n_chk++; if (clint_tirq !== m_tirq || clint_sirq !== m_msip) begin n_fail++;
        $display("FAIL rand_irq %0d: got tirq=%b sirq=%b want %b/%b", i, clint_tirq, clint_sirq, m_tirq, m_msip); end
      a = {$urandom(), $urandom()};
      case ($urandom_range(0, 9))
        0: a[15:0] = 16'h0000;  1: a[15:0] = 16'h0004;  2: a[15:0] = 16'h0008;
        3: a[15:0] = 16'h4000;  4: a[15:0] = 16'h4008;  5: a[15:0] = 16'h4010;
        6: a[15:0] = 16'hbff0;  7: a[15:0] = 16'hbff8;  8: a[15:0] = 16'h0002;
        default: a[15:0] = 16'($urandom());
      endcase
      bus.clint_addr  = a;
      bus.clint_wdata = (a[15:0] == 16'hbff0) ? 64'($urandom_range(0, 7)) :
                        (a[15:0] == 16'hbff8) ? 64'($urandom_range(0, 64)) : {$urandom(), $urandom()};
      bus.clint_wstrb = 8'($urandom());
      bus.clint_wen   = 1'($urandom());
      bus.clint_sel   = ($urandom_range(0, 3) != 0);
      @(negedge clock);
    end
    bus.clint_sel = 1'b0; bus.clint_wen = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    bus_go(16'h0000, 64'd1, 8'h01, 1'b1);
    bus.clint_addr = 64'h4000; bus.clint_wen = 1'b0; bus.clint_sel = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_chk++; if (bus.clint_rdata !== 64'd0 || bus.clint_ack !== 1'b0) begin n_fail++;
      $display("FAIL midreset_port: got rdata=%h ack=%b want 0/0", bus.clint_rdata, bus.clint_ack); end
    n_chk++; if (clint_tirq !== 2'b00 || clint_sirq !== 2'b00) begin n_fail++;
      $display("FAIL midreset_irq: got tirq=%b sirq=%b want 00/00", clint_tirq, clint_sirq); end
    @(negedge clock);
    bus.clint_sel = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    n_chk++; if (bus.clint_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_no_ack: got %b want 0", bus.clint_ack); end
    for (int h = 0; h < NH; h++) begin
      bus_go(16'h4000 + 16'(8*h), 64'd0, 8'h00, 1'b0);
      n_chk++; if (bus.clint_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++;
        $display("FAIL midreset_cmp%0d: got %h want all-ones", h, bus.clint_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_mtime_idle();
    test_timer_irq();
    test_mtime_wrap();
    test_byte_strobe();
    test_back_to_back();
    test_msip();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clint_multi_hart.md
Name: clint_multi_hart

Overview:
- Parametrised successor of the single-hart CLINT core-local interruptor.
- Provides one shared mtime counter with a runtime-programmable tick prescaler.
- Per hart: an mtimecmp register and an msip software-interrupt bit, exposed through a byte-strobed register port.
- Sits beside the LSU/AXI bridge on the memory-mapped CLINT window; drives timer and software IRQ lines into each hart's CSR unit.

Parameters:
- NUM_HARTS, 2, number of harts served (1..16).
- DATA_WIDTH, 64, register port data width; mtime and mtimecmp are DATA_WIDTH bits.
- TICK_COUNT, 'h100, reset value of the prescaler register; tick period = prescale+1 cycles.
- PRESCALE_WIDTH, 32, width of the prescaler register and the internal cycle counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clint_addr  in  DATA_WIDTH  byte address; only bits [15:0] are decoded.
- clint_wdata  in  DATA_WIDTH  write data.
- clint_wstrb  in  DATA_WIDTH/8  byte write enables.
- clint_wen  in  1  write request (qualified by clint_sel).
- clint_sel  in  1  access strobe, one cycle per access.
- clint_rdata  out  DATA_WIDTH  registered read data.
- clint_ack  out  1  one-cycle pulse, cycle after an access.
- clint_tirq  out  NUM_HARTS  per-hart machine timer interrupt.
- clint_sirq  out  NUM_HARTS  per-hart machine software interrupt.

Behaviour:
- Address map (offsets on [15:0]):
  - msip[h] at 0x0000+4*h; bit 0 only, other bits read 0.
  - mtimecmp[h] at 0x4000+8*h.
  - prescale at 0xbff0; zero-extended on read.
  - mtime at 0xbff8.
  - Other offsets, and hart indices >= NUM_HARTS: reads return 0, writes are ignored, ack still pulses.
- Reset values:
  - mtime = 0; mtimecmp[h] = all-ones, so no IRQ out of reset.
  - msip = 0; prescale = TICK_COUNT; cycle counter = 0.
  - clint_rdata = 0; clint_ack = 0; clint_tirq = 0; clint_sirq = 0.
- Writes, when clint_sel & clint_wen: target bytes with wstrb[i]=1 take wdata byte i; bytes with wstrb[i]=0 are unchanged.
  - msip takes wdata[0] when wstrb[0]=1.
  - prescale uses the strobes that fall within PRESCALE_WIDTH.
- Reads: when clint_sel=1, clint_rdata <= selected register value one cycle later (1-cycle latency), regardless of clint_wen.
  - A read that coincides with a write returns the pre-write value.
  - clint_rdata holds its value when clint_sel=0.
- clint_ack <= clint_sel every cycle; back-to-back accesses are allowed, one per cycle.
- Prescaler:
  - The counter increments each cycle.
  - When counter == prescale: tick is asserted, counter returns to 0, and mtime <= mtime+1.
  - prescale=0 gives a tick every cycle.
  - Any write to prescale also clears the counter that cycle; no tick occurs that cycle.
  - If prescale is written below the current counter value, the counter is cleared by the write rule, so there is no long wrap.
- mtime arithmetic: unsigned, modulo 2^DATA_WIDTH; all-ones + 1 = 0.
- Simultaneous software write and tick on mtime: the write wins, merged per strobe from the old value, and the increment is dropped.
- Interrupts:
  - clint_tirq[h] is registered: <= (mtime >= mtimecmp[h]), unsigned compare of current register values.
  - The IRQ therefore asserts one cycle after the condition becomes true and deasserts one cycle after it becomes false.
  - clint_sirq[h] = msip[h] register output (registered by construction).
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). A pending access is lost and no ack is issued.

Test Plan:
- Reset, then idle 3*(TICK_COUNT+1) cycles -> mtime reads 3 (reading 0xbff8 returns 3 one cycle after sel); clint_tirq=0 for all harts.
- Write prescale=0, then mtimecmp[1]=10 with wstrb=0xFF, then mtime=0 -> clint_tirq[1] rises exactly 11 cycles after the mtime write completes; clint_tirq[0] stays 0.
- Write mtime=0xFFFF_FFFF_FFFF_FFFF with prescale=0 -> next cycle mtime=0; write the same cycle as a tick with wdata=5 -> mtime=5, not 6.
- Byte-strobe write of 0xAA to mtimecmp[0] with wstrb=0x01 -> reads 0xFFFF_FFFF_FFFF_FFAA; write to 0x4000+8*NUM_HARTS -> read returns 0, ack pulses.
- Write msip[1]=1 (addr 0x0004), then 0 -> clint_sirq[1] high for the cycles between the two writes; clint_sirq[0] stays 0.
- Assert reset while clint_sel=1 mid-access -> clint_rdata=0, clint_ack=0, mtimecmp all-ones, all IRQs 0 immediately without waiting for a clock edge.
